// File: rtl/fifo_param_if.sv
// Push/pop handshake bundle for fifo_param: producer/consumer side is master,
// the FIFO itself is slave.
interface fifo_param_if #(
  parameter int DATA_W = 6
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              pause;
  logic              can_pop;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, pause, can_pop
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, pause, can_pop
  );
endinterface

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy count, threshold flags,
// error pulses and a sticky error bit; registered or fall-through read.
module fifo_param #(
  parameter  int DATA_W = 6,
  parameter  int DEPTH  = 8,
  parameter  int FWFT   = 0,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   io,
  input  logic [CW-1:0] thr_af,
  input  logic [CW-1:0] thr_ae,
  input  logic          err_clr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          wr_err,
  output logic          rd_err,
  output logic          err_sticky
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [CW:0]       af_sum;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = io.wr_en && !full && !reset;
  assign pop   = io.rd_en && !empty && !reset;

  // Widened by one bit so a large margin cannot wrap the sum back below DEPTH.
  assign af_sum       = {1'b0, count} + {1'b0, thr_af};
  assign almost_full  = (af_sum >= DEPTH_X);
  assign almost_empty = (count <= thr_ae);
  assign io.pause     = almost_full | full;
  assign io.can_pop   = !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      wr_err <= io.wr_en && full;
      rd_err <= io.rd_en && empty;
      // A pulse visible this cycle outranks a clear request.
      if (wr_err || rd_err) err_sticky <= 1'b1;
      else if (err_clr)     err_sticky <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign io.rd_data  = mem[rd_ptr];
      assign io.rd_valid = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_q;
      logic              rv_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rv_q <= pop;
          if (pop) rd_q <= mem[rd_ptr];
        end
      end

      assign io.rd_data  = rd_q;
      assign io.rd_valid = rv_q;
    end
  endgenerate

endmodule
